// File: rtl/alu_pkg.sv
// Shared constants and state encoding for the BNE flag path.
package alu_pkg;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned FCNT_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RESOLVE = 2'd1,
        FLUSH   = 2'd2
    } state_e;

endpackage

// File: rtl/bne_branch_resolver_pc_adder.sv
// Wrapping next-PC adder: base + 1 + offset, modulo 2^WORD_W.
module pc_adder
    import alu_pkg::*;
(
    input  logic [WORD_W-1:0] base,
    input  logic [WORD_W-1:0] offset,
    output logic [WORD_W-1:0] sum
);

    assign sum = base + WORD_W'(1) + offset;

endmodule

// File: rtl/bne_branch_resolver.sv
// Resolves BNE branches from the ALU flag, owns the PC and drives the
// post-branch fetch/decode flush.
module bne_branch_resolver
    import alu_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC     = 16'h0000,
    parameter int unsigned       FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              step,
    input  logic              br_valid,
    output logic              br_ready,
    input  logic [WORD_W-1:0] flag,
    input  logic [WORD_W-1:0] offset,
    output logic [WORD_W-1:0] pc,
    output logic              flush,
    output logic              stall,
    output logic [WORD_W-1:0] taken_cnt
);

    state_e              state;
    logic                taken_q;
    logic [WORD_W-1:0]   off_q;
    logic [FCNT_W-1:0]   fcnt;
    logic [WORD_W-1:0]   add_off;
    logic [WORD_W-1:0]   next_pc;

    // One adder serves both pc+1 (offset forced to zero) and the branch target.
    assign add_off = (state == RESOLVE && taken_q) ? off_q : '0;

    pc_adder u_pc_adder (
        .base   (pc),
        .offset (add_off),
        .sum    (next_pc)
    );

    // Pure decodes of the state register, so no glitches relative to clk.
    assign stall    = (state != IDLE);
    assign flush    = (state == FLUSH);
    assign br_ready = (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            taken_cnt <= '0;
            taken_q   <= 1'b0;
            off_q     <= '0;
            fcnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // A branch also accounts for this slot's +1, so step is dropped.
                    if (br_valid) begin
                        taken_q <= |flag;
                        off_q   <= offset;
                        state   <= RESOLVE;
                    end else if (step) begin
                        pc <= next_pc;
                    end
                end
                RESOLVE: begin
                    pc <= next_pc;
                    if (taken_q) begin
                        if (taken_cnt != '1) begin
                            taken_cnt <= taken_cnt + WORD_W'(1);
                        end
                        if (FLUSH_CYCLES != 0) begin
                            fcnt  <= FCNT_W'(FLUSH_CYCLES - 1);
                            state <= FLUSH;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                FLUSH: begin
                    if (fcnt == '0) begin
                        state <= IDLE;
                    end else begin
                        fcnt <= fcnt - FCNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bne_branch_resolver.sv
// Directed per-cycle vector bench for bne_branch_resolver.
module tb_bne_branch_resolver;

    logic        clk;
    logic        rst_n;
    logic        step;
    logic        br_valid;
    logic        br_ready;
    logic [15:0] flag;
    logic [15:0] offset;
    logic [15:0] pc;
    logic        flush;
    logic        stall;
    logic [15:0] taken_cnt;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic        step;
        logic        br_valid;
        logic [15:0] flag;
        logic [15:0] offset;
        logic [15:0] e_pc;
        logic        e_flush;
        logic        e_stall;
        logic        e_ready;
        logic [15:0] e_cnt;
        string       name;
    } vec_t;

    vec_t vecs[$];

    bne_branch_resolver #(
        .RESET_PC     (16'h0010),
        .FLUSH_CYCLES (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .step      (step),
        .br_valid  (br_valid),
        .br_ready  (br_ready),
        .flag      (flag),
        .offset    (offset),
        .pc        (pc),
        .flush     (flush),
        .stall     (stall),
        .taken_cnt (taken_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic s, input logic v, input logic [15:0] f, input logic [15:0] o,
                       input logic [15:0] e_pc, input logic ef, input logic es, input logic er,
                       input logic [15:0] ec, input string n);
        vec_t t;
        t.step = s; t.br_valid = v; t.flag = f; t.offset = o;
        t.e_pc = e_pc; t.e_flush = ef; t.e_stall = es; t.e_ready = er; t.e_cnt = ec;
        t.name = n;
        vecs.push_back(t);
    endtask

    task automatic check(input string n, input logic [15:0] e_pc, input logic ef, input logic es,
                         input logic er, input logic [15:0] ec);
        tests_run++;
        if (pc !== e_pc || flush !== ef || stall !== es || br_ready !== er || taken_cnt !== ec) begin
            tests_failed++;
            $display("FAIL %s: got pc=%h flush=%b stall=%b ready=%b cnt=%h, want pc=%h flush=%b stall=%b ready=%b cnt=%h",
                     n, pc, flush, stall, br_ready, taken_cnt, e_pc, ef, es, er, ec);
        end
    endtask

    // Drive inputs on the falling edge, then sample 1 time unit after the rising edge.
    task automatic cyc(input logic s, input logic v, input logic [15:0] f, input logic [15:0] o);
        @(negedge clk);
        step = s; br_valid = v; flag = f; offset = o;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; step = 1'b0; br_valid = 1'b0; flag = '0; offset = '0;

        // Reset, then steps up to 0x0020.
        add(1, 0, 16'h0000, 16'h0000, 16'h0011, 0, 0, 1, 16'd0, "step1");
        add(1, 0, 16'h0000, 16'h0000, 16'h0012, 0, 0, 1, 16'd0, "step2");
        add(1, 0, 16'h0000, 16'h0000, 16'h0013, 0, 0, 1, 16'd0, "step3");
        for (int i = 0; i < 13; i++)
            add(1, 0, 16'h0000, 16'h0000, 16'(16'h0014 + i), 0, 0, 1, 16'd0, "step_run");
        // Taken, offset -4 from 0x0020.
        add(0, 1, 16'h0001, 16'hFFFC, 16'h0020, 0, 1, 0, 16'd0, "tk_accept");
        add(0, 0, 16'h0000, 16'h0000, 16'h001D, 1, 1, 0, 16'd1, "tk_flush1");
        add(0, 0, 16'h0000, 16'h0000, 16'h001D, 1, 1, 0, 16'd1, "tk_flush2");
        add(0, 0, 16'h0000, 16'h0000, 16'h001D, 0, 0, 1, 16'd1, "tk_ready");
        add(1, 0, 16'h0000, 16'h0000, 16'h001E, 0, 0, 1, 16'd1, "step_1e");
        add(1, 0, 16'h0000, 16'h0000, 16'h001F, 0, 0, 1, 16'd1, "step_1f");
        add(1, 0, 16'h0000, 16'h0000, 16'h0020, 0, 0, 1, 16'd1, "step_20");
        // Not taken from 0x0020.
        add(0, 1, 16'h0000, 16'h0005, 16'h0020, 0, 1, 0, 16'd1, "nt_accept");
        add(0, 0, 16'h0000, 16'h0000, 16'h0021, 0, 0, 1, 16'd1, "nt_done");
        // step+br_valid together, then both pulsed through RESOLVE/FLUSH.
        add(1, 1, 16'h0040, 16'h0010, 16'h0021, 0, 1, 0, 16'd1, "both_accept");
        add(1, 1, 16'h0000, 16'h0000, 16'h0032, 1, 1, 0, 16'd2, "resolve_ignores");
        add(1, 1, 16'h0000, 16'h0000, 16'h0032, 1, 1, 0, 16'd2, "flush_ignores");
        add(1, 1, 16'h0000, 16'h0000, 16'h0032, 0, 0, 1, 16'd2, "flush_end_ignores");
        add(0, 0, 16'h0000, 16'h0000, 16'h0032, 0, 0, 1, 16'd2, "idle_hold");
        // Large negative offset to 0xFFFE.
        add(0, 1, 16'h0100, 16'hFFCB, 16'h0032, 0, 1, 0, 16'd2, "neg_accept");
        add(0, 0, 16'h0000, 16'h0000, 16'hFFFE, 1, 1, 0, 16'd3, "neg_flush1");
        add(0, 0, 16'h0000, 16'h0000, 16'hFFFE, 1, 1, 0, 16'd3, "neg_flush2");
        add(0, 0, 16'h0000, 16'h0000, 16'hFFFE, 0, 0, 1, 16'd3, "neg_ready");
        // MSB-only flag, target wraps past 0xFFFF.
        add(0, 1, 16'h8000, 16'h0003, 16'hFFFE, 0, 1, 0, 16'd3, "msb_accept");
        add(0, 0, 16'h0000, 16'h0000, 16'h0002, 1, 1, 0, 16'd4, "wrap_flush1");
        add(0, 0, 16'h0000, 16'h0000, 16'h0002, 1, 1, 0, 16'd4, "wrap_flush2");
        add(0, 0, 16'h0000, 16'h0000, 16'h0002, 0, 0, 1, 16'd4, "wrap_ready");
        // Backward wrap to 0xFFFF, then step wraps to 0x0000.
        add(0, 1, 16'hFFFF, 16'hFFFC, 16'h0002, 0, 1, 0, 16'd4, "bwd_accept");
        add(0, 0, 16'h0000, 16'h0000, 16'hFFFF, 1, 1, 0, 16'd5, "bwd_flush1");
        add(0, 0, 16'h0000, 16'h0000, 16'hFFFF, 1, 1, 0, 16'd5, "bwd_flush2");
        add(0, 0, 16'h0000, 16'h0000, 16'hFFFF, 0, 0, 1, 16'd5, "bwd_ready");
        add(1, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1, 16'd5, "step_wrap");

        #12;
        check("reset", 16'h0010, 0, 0, 1, 16'd0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            cyc(vecs[i].step, vecs[i].br_valid, vecs[i].flag, vecs[i].offset);
            check(vecs[i].name, vecs[i].e_pc, vecs[i].e_flush, vecs[i].e_stall,
                  vecs[i].e_ready, vecs[i].e_cnt);
        end

        // Saturation: preload the counter at its ceiling, then take a branch.
        @(negedge clk);
        step = 1'b0; br_valid = 1'b0; flag = '0; offset = '0;
        force dut.taken_cnt = 16'hFFFF;
        #1;
        release dut.taken_cnt;
        check("sat_preload", 16'h0000, 0, 0, 1, 16'hFFFF);
        cyc(0, 1, 16'h0001, 16'h0000);
        check("sat_accept", 16'h0000, 0, 1, 0, 16'hFFFF);
        cyc(0, 0, 16'h0000, 16'h0000);
        check("sat_hold", 16'h0001, 1, 1, 0, 16'hFFFF);
        cyc(0, 0, 16'h0000, 16'h0000);
        cyc(0, 0, 16'h0000, 16'h0000);
        check("sat_ready", 16'h0001, 0, 0, 1, 16'hFFFF);

        // Asynchronous reset in the middle of FLUSH.
        cyc(0, 1, 16'h0004, 16'h0005);
        cyc(0, 0, 16'h0000, 16'h0000);
        check("pre_reset_flush", 16'h0007, 1, 1, 0, 16'hFFFF);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_reset", 16'h0010, 0, 0, 1, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_idle", 16'h0010, 0, 0, 1, 16'd0);
        cyc(1, 0, 16'h0000, 16'h0000);
        check("post_reset_step", 16'h0011, 0, 0, 1, 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
